// File: rtl/complex_block_merge.sv
// Purpose : merges a real-product beat and a cross-product beat into one complex result row (Cr = P1-P2, Ci = P1+P2 per element).
// Latency : result valid the cycle after the cross beat is accepted.
// Backpress: in_ready drops while a result is held; the result stays frozen until out_ready is seen.

`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef MATRIX_DIM
`define MATRIX_DIM 4
`endif
`ifndef REAL_SET
`define REAL_SET 1'b0
`endif

module complex_block_merge #(
    parameter int W = `WORD_LEN,
    parameter int N = `MATRIX_DIM
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_phase,
    input  logic [W*N-1:0] P1,
    input  logic [W*N-1:0] P2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*N-1:0] Cr,
    output logic [W*N-1:0] Ci,
    output logic           out_last,
    output logic           phase_err
);

    // Row counter needs at least one bit even for a single-row block.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    localparam logic [1:0] S_REAL  = 2'd0;
    localparam logic [1:0] S_CROSS = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [W*N-1:0] diff;
    logic [W*N-1:0] sum;
    logic           accept;
    logic           is_real;
    logic           out_fire;

    // Per-element arithmetic; each lane wraps at W bits with no carry into its neighbour.
    for (genvar k = 0; k < N; k++) begin : g_lane
        assign diff[k*W +: W] = P1[k*W +: W] - P2[k*W +: W];
        assign sum[k*W +: W]  = P1[k*W +: W] + P2[k*W +: W];
    end

    assign in_ready  = (state != S_OUT);
    assign accept    = in_valid & in_ready;
    assign is_real   = (in_phase == `REAL_SET);
    assign out_valid = (state == S_OUT);
    assign out_fire  = out_valid & out_ready;
    assign out_last  = out_valid & (cnt == CNT_MAX);

    // Pairing FSM: real beat, then cross beat, then hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REAL;
        end else begin
            case (state)
                S_REAL:  if (accept && is_real)  state <= S_CROSS;
                S_CROSS: if (accept && !is_real) state <= S_OUT;
                S_OUT:   if (out_ready)          state <= S_REAL;
                default:                         state <= S_REAL;
            endcase
        end
    end

    // Real row: loaded by an in-order real beat, and re-loaded by a repeated real beat while waiting for the cross beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Cr <= '0;
        end else if (accept && is_real && (state == S_REAL || state == S_CROSS)) begin
            Cr <= diff;
        end
    end

    // Imaginary row: loaded only by the cross beat that completes a pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ci <= '0;
        end else if (accept && !is_real && state == S_CROSS) begin
            Ci <= sum;
        end
    end

    // Out-of-order flag: one-cycle pulse for a cross beat while awaiting real, or a real beat while awaiting cross.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_err <= 1'b0;
        end else begin
            phase_err <= accept && ((state == S_REAL && !is_real) || (state == S_CROSS && is_real));
        end
    end

    // Row position within the block advances once per consumed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_fire) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_complex_block_merge.sv
// Purpose : directed checks of complex_block_merge at W=16, N=4.
// Latency : inputs driven 1 time unit after posedge, outputs sampled 1 time unit after the next posedge.
// Backpress: out_ready held low explicitly where result hold behaviour is exercised.

module tb_complex_block_merge;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_phase;
    logic [W*N-1:0] P1;
    logic [W*N-1:0] P2;
    logic           out_valid;
    logic           out_ready;
    logic [W*N-1:0] Cr;
    logic [W*N-1:0] Ci;
    logic           out_last;
    logic           phase_err;

    int n_checks = 0;
    int n_pass   = 0;

    complex_block_merge #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_phase  (in_phase),
        .P1        (P1),
        .P2        (P2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Cr        (Cr),
        .Ci        (Ci),
        .out_last  (out_last),
        .phase_err (phase_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One beat presented for exactly one clock edge; returns 1 unit after that edge.
    task automatic beat(input logic ph, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_phase = ph;
        P1       = a;
        P2       = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        P1       = '0;
        P2       = '0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_phase  = 1'b0;
        P1        = '0;
        P2        = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_cr",        Cr,             64'd0);
        check("rst_ci",        Ci,             64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_phase_err", 64'(phase_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic pair: 7-3 = 4, 2+4 = 6 in element 0.
        beat(1'b0, 64'd7, 64'd3);
        check("t1_mid_out_valid", 64'(out_valid), 64'd0);
        check("t1_mid_phase_err", 64'(phase_err), 64'd0);
        beat(1'b1, 64'd2, 64'd4);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_cr",        Cr,             64'h0000_0000_0000_0004);
        check("t1_ci",        Ci,             64'h0000_0000_0000_0006);
        check("t1_out_last",  64'(out_last),  64'd0);
        check("t1_in_ready",  64'(in_ready),  64'd0);
        consume();
        check("t1_done_valid", 64'(out_valid), 64'd0);

        // Wrap within element 1 with non-zero neighbours (no borrow/carry leakage).
        beat(1'b0, 64'h0000_0010_0000_0020, 64'h0000_0003_0001_0005);
        beat(1'b1, 64'h0000_0001_FFFF_0003, 64'h0000_0002_0002_0004);
        check("t2_cr", Cr, 64'h0000_000D_FFFF_001B);
        check("t2_ci", Ci, 64'h0000_0003_0001_0007);

        // Hold under backpressure while upstream keeps offering beats.
        in_valid = 1'b1;
        in_phase = 1'b0;
        P1       = 64'h1111_2222_3333_4444;
        P2       = 64'h0101_0202_0303_0404;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_cr",    Cr,             64'h0000_000D_FFFF_001B);
            check("t3_hold_ci",    Ci,             64'h0000_0003_0001_0007);
            check("t3_hold_ready", 64'(in_ready),  64'd0);
            check("t3_hold_perr",  64'(phase_err), 64'd0);
        end
        in_valid = 1'b0;
        consume();
        check("t3_release_valid", 64'(out_valid), 64'd0);
        check("t3_release_ready", 64'(in_ready),  64'd1);
        check("t3_release_cr",    Cr,             64'h0000_000D_FFFF_001B);

        // Cross beat while awaiting real: flagged and discarded.
        beat(1'b1, 64'd9, 64'd9);
        check("t4_perr",       64'(phase_err), 64'd1);
        check("t4_perr_valid", 64'(out_valid), 64'd0);
        check("t4_perr_ready", 64'(in_ready),  64'd1);
        check("t4_perr_ci",    Ci,             64'h0000_0003_0001_0007);
        @(posedge clk); #1;
        check("t4_perr_clear", 64'(phase_err), 64'd0);
        // Repeated real beat while awaiting cross overwrites Cr.
        beat(1'b0, 64'd100, 64'd1);
        check("t4_cr_first", Cr, 64'd99);
        beat(1'b0, 64'd50, 64'd8);
        check("t4_perr2",       64'(phase_err), 64'd1);
        check("t4_cr_overwrite", Cr,            64'd42);
        check("t4_perr2_valid", 64'(out_valid), 64'd0);
        beat(1'b1, 64'd1, 64'd1);
        check("t4_valid",    64'(out_valid), 64'd1);
        check("t4_ci",       Ci,             64'd2);
        check("t4_cr",       Cr,             64'd42);
        check("t4_perr_off", 64'(phase_err), 64'd0);
        check("t4_last",     64'(out_last),  64'd0);
        consume();

        // Reset mid-pair drops the partial real beat.
        beat(1'b0, 64'd20, 64'd5);
        rst_n = 1'b0;
        #2;
        check("t5_rst_cr",    Cr,             64'd0);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_perr",  64'(phase_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(1'b1, 64'd3, 64'd4);
        check("t5_cross_perr",  64'(phase_err), 64'd1);
        check("t5_cross_valid", 64'(out_valid), 64'd0);
        check("t5_cross_ci",    Ci,             64'd0);

        // Five results from a fresh block: out_last only on the fourth.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            beat(1'b0, 64'(i + 10), 64'd1);
            beat(1'b1, 64'(i), 64'd2);
            check("t6_valid", 64'(out_valid), 64'd1);
            check("t6_cr",    Cr,             64'(i + 9));
            check("t6_ci",    Ci,             64'(i + 2));
            check("t6_last",  64'(out_last),  (i == 3) ? 64'd1 : 64'd0);
            consume();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
